// File: rtl/pla_minterm_scanner_pkg.sv
// Shared types and widths for the PLA minterm scanner.
// Used by the top module and the function evaluator.
package pla_scan_pkg;
  localparam int VEC_W = 8;
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/pla_minterm_scanner_xcpla_fn_eval.sv
// Purely combinational evaluator for the benchmark function f(x7..x0).
// Swap this module out to scan a different PLA function.
module xcpla_fn_eval
  import pla_scan_pkg::*;
(
  input  logic [VEC_W-1:0] x,
  output logic             f
);
  logic g;
  logic h;

  always_comb begin
    g = x[3] ^ (x[0] & ~(x[3] ^ x[4]) & (x[4] ^ (~x[1] & x[2])));
    h = x[4] & (x[0] | x[1] | x[2]);
    f = ~(x[6] & ~x[7] & (x[5] ? h : g));
  end
endmodule

// File: rtl/pla_minterm_scanner.sv
// Scans all 256 input vectors, one per cycle, and hands out those where f == target.
// Optional 9-bit saturating hit counter behind PLA_MINTERM_SCANNER_HIT_COUNT_EN.
module pla_minterm_scanner
  import pla_scan_pkg::*;
#(
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       target,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_vec,
  output logic       busy,
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
  output logic [8:0] hit_count,
`endif
  output logic       done
);
  localparam logic [VEC_W-1:0] IDX_FIRST = DESCEND ? 8'hFF : 8'h00;
  localparam logic [VEC_W-1:0] IDX_LAST  = DESCEND ? 8'h00 : 8'hFF;
  localparam logic [VEC_W-1:0] IDX_ONE   = 8'h01;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             tgt_q, tgt_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             f_val;
  logic             idx_last;
  logic [VEC_W-1:0] idx_step;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
  localparam logic [CNT_W-1:0] HIT_MAX = 9'd256;
  logic [CNT_W-1:0] hit_q, hit_d;
`endif

  xcpla_fn_eval u_fn (
    .x (idx_q),
    .f (f_val)
  );

  assign idx_last = (idx_q == IDX_LAST);
  assign idx_step = DESCEND ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    tgt_d   = tgt_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    hit_d   = hit_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SCAN;
          idx_d   = IDX_FIRST;
          tgt_d   = target;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
          hit_d   = '0;
`endif
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (f_val == tgt_q) begin
          vec_d   = idx_q;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else if (idx_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_step;
        end
      end
      HOLD: begin
        // vld_q is always set here, so a ready seen during SCAN never counts
        if (abort) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (out_ready) begin
          vld_d = 1'b0;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
          if (hit_q != HIT_MAX) hit_d = hit_q + 9'd1;
`endif
          if (idx_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_step;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      tgt_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
      hit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      tgt_q   <= tgt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign out_vec   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
  assign hit_count = hit_q;
`endif
endmodule

// File: tb/tb_pla_minterm_scanner.sv
// Bench for pla_minterm_scanner: ascending and descending instances checked against a
// truth-table model; PLA_MINTERM_SCANNER_HIT_COUNT_EN enables the hit_count checks.
module tb_pla_minterm_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, target_i, start_i, abort_i, rdy_i, sel;
  logic start_a, abort_a, rdy_a, start_b, abort_b, rdy_b;
  logic vld_a, vld_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] vec_a, vec_b;
  logic o_vld, o_busy, o_done;
  logic [7:0] o_vec;
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
  logic [8:0] hc_a, hc_b, o_hc;
  assign o_hc = sel ? hc_b : hc_a;
`endif

  assign start_a = start_i & ~sel;
  assign abort_a = abort_i & ~sel;
  assign rdy_a   = rdy_i & ~sel;
  assign start_b = start_i & sel;
  assign abort_b = abort_i & sel;
  assign rdy_b   = rdy_i & sel;
  assign o_vld   = sel ? vld_b : vld_a;
  assign o_vec   = sel ? vec_b : vec_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;

  pla_minterm_scanner #(.DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .start(start_a), .target(target_i), .abort(abort_a),
    .out_ready(rdy_a), .out_valid(vld_a), .out_vec(vec_a), .busy(busy_a),
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    .hit_count(hc_a),
`endif
    .done(done_a)
  );

  pla_minterm_scanner #(.DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .start(start_b), .target(target_i), .abort(abort_b),
    .out_ready(rdy_b), .out_valid(vld_b), .out_vec(vec_b), .busy(busy_b),
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    .hit_count(hc_b),
`endif
    .done(done_b)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int acc_n;
  logic [7:0] acc_first, acc_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit f_ref(input logic [7:0] x);
    bit g, h;
    g = x[3] ^ (x[0] & (x[3] == x[4]) & (x[4] ^ (!x[1] && x[2])));
    h = x[4] && (x[2:0] != 3'b000);
    return !(x[6] && !x[7] && (x[5] ? h : g));
  endfunction

  // Expected accepted vectors, in scan order, from the truth table.
  function automatic void build_exp(input bit tgt, input bit desc);
    logic [7:0] v;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      v = desc ? 8'(255 - i) : 8'(i);
      if (f_ref(v) == tgt) exp_q.push_back(v);
    end
  endfunction

  // mode 0: ready always high (cycle-exact timing); 1: random ready/start; 2: 10-cycle stall on first hit
  task automatic run_scan(input bit s, input bit tgt, input int mode, input string tag);
    int k, done_k, dones, bad_seq, bad_time, bad_hold, bad_busy, hold_cnt, p;
    bit r, prev_hold;
    logic [7:0] prev_vec;
    k = 1; done_k = 0; dones = 0; bad_seq = 0; bad_time = 0; bad_hold = 0; bad_busy = 0;
    hold_cnt = 0; prev_hold = 1'b0; prev_vec = 8'h00;
    acc_n = 0; acc_first = 8'h00; acc_last = 8'h00;
    sel = s;
    build_exp(tgt, s);
    target_i = tgt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (k < 1500 && !(done_k > 0 && k > done_k)) begin
      if (mode == 1) begin
        r = 1'($urandom_range(0, 1));
        start_i = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        r = !(acc_n == 0 && hold_cnt < 10);
      end else begin
        r = 1'b1;
      end
      rdy_i = r;
      if (!o_busy) bad_busy++;
      if (o_done) begin
        dones++;
        if (done_k == 0) done_k = k;
      end
      if (o_vld) begin
        if (prev_hold && o_vec !== prev_vec) bad_hold++;
        if (r) begin
          p = s ? 255 - int'(o_vec) : int'(o_vec);
          if (mode == 0 && k != p + 2 + acc_n) bad_time++;
          if (acc_n >= exp_q.size() || o_vec !== exp_q[acc_n]) bad_seq++;
          if (acc_n == 0) acc_first = o_vec;
          acc_last = o_vec;
          acc_n++;
        end else begin
          hold_cnt++;
        end
        prev_hold = !r;
        prev_vec = o_vec;
      end else begin
        if (prev_hold) bad_hold++;
        prev_hold = 1'b0;
      end
      tick();
      k++;
    end
    start_i = 1'b0;
    rdy_i = 1'b0;
    check({tag, "_done_once"}, dones, 1);
    check({tag, "_done_low_after"}, o_done, 0);
    check({tag, "_count"}, acc_n, exp_q.size());
    check({tag, "_sequence"}, bad_seq, 0);
    check({tag, "_hold_stable"}, bad_hold, 0);
    check({tag, "_busy_during"}, bad_busy, 0);
    check({tag, "_idle_after"}, {o_busy, o_vld}, 2'b00);
    if (mode == 0) begin
      check({tag, "_hit_timing"}, bad_time, 0);
      check({tag, "_done_cycle"}, done_k, 257 + exp_q.size());
    end
    if (mode == 2) check({tag, "_stall_cycles"}, hold_cnt, 10);
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    check({tag, "_hit_count"}, o_hc, exp_q.size());
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; rdy_i = 1'b0; target_i = 1'b0; sel = 1'b0;
    #12;
    check("reset_asc", {vld_a, vec_a, busy_a, done_a}, 11'h000);
    check("reset_desc", {vld_b, vec_b, busy_b, done_b}, 11'h000);
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    check("reset_hit_count", {hc_a, hc_b}, 18'h0);
`endif
    rst_n = 1'b1;
    tick();

    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("start_with_abort_ignored", o_busy, 0);

    run_scan(1'b0, 1'b0, 0, "asc");
    check("asc_first", acc_first, 8'h45);
    check("asc_last", acc_last, 8'h7F);
    check("asc_n28", acc_n, 28);

    run_scan(1'b0, 1'b1, 0, "full");
    check("full_first", acc_first, 8'h00);
    check("full_last", acc_last, 8'hFF);
    check("full_n228", acc_n, 228);

    run_scan(1'b0, 1'b0, 2, "bp");
    check("bp_first", acc_first, 8'h45);
    check("bp_second", exp_q[1], 8'h48);

    // Abort while holding the third hit, with ready also high.
    sel = 1'b0; target_i = 1'b0; rdy_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (o_vld) n++;
      if (n == 3) break;
      tick();
    end
    check("abort_reached_3rd_hit", n, 3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_idle", {o_vld, o_busy, o_done}, 3'b000);
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    check("abort_hit_count", o_hc, 2);
`endif
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_done || o_busy) dn++;
    end
    check("abort_no_done", dn, 0);
    rdy_i = 1'b0;

    // Asynchronous reset in the middle of a scan.
    sel = 1'b0; target_i = 1'b0; rdy_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (o_vld) n++;
      tick();
      if (n == 2) break;
    end
    check("rst_pre_busy", {o_busy, o_vec}, {1'b1, 8'h48});
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_scan", {o_vld, o_vec, o_busy, o_done}, 11'h000);
`ifdef PLA_MINTERM_SCANNER_HIT_COUNT_EN
    check("rst_mid_scan_hit_count", o_hc, 0);
`endif
    #2 rst_n = 1'b1;
    rdy_i = 1'b0;
    run_scan(1'b0, 1'b0, 0, "rerun");
    check("rerun_first", acc_first, 8'h45);
    check("rerun_last", acc_last, 8'h7F);

    run_scan(1'b1, 1'b0, 0, "desc");
    check("desc_first", acc_first, 8'h7F);
    check("desc_last", acc_last, 8'h45);
    check("desc_n28", acc_n, 28);

    for (int i = 0; i < 3; i++) begin
      run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
